// File: rtl/midi_note_tx.sv
`default_nettype none
// ============================================================================
// midi_note_tx : debounced push-buttons -> MIDI Note On/Off on a UART line
// Rev 1.0      : initial release
// ============================================================================
module midi_note_tx #(
  parameter int NUM_BTNS       = 4,
  parameter int BAUD_DIV       = 3200,
  parameter int DEBOUNCE_CYC   = 1000000,
  parameter int BASE_NOTE      = 60,
  parameter int VELOCITY       = 100,
  parameter int RUNNING_STATUS = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn,
  input  logic [3:0]          channel,
  output logic                midi_tx,
  output logic                busy,
  output logic                led
);

  localparam int c_baud_w = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int c_db_w   = (DEBOUNCE_CYC > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam int c_idx_w  = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1;

  localparam logic [c_baud_w-1:0] c_baud_max = c_baud_w'(BAUD_DIV - 1);
  localparam logic [c_db_w-1:0]   c_db_max   = c_db_w'(DEBOUNCE_CYC - 1);
  localparam logic [7:0]          c_velocity = 8'(VELOCITY & 127);
  localparam logic [6:0]          c_base     = 7'(BASE_NOTE);
  localparam logic                c_rs       = (RUNNING_STATUS != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t r_state, w_state_next;

  // Free-running baud counter
  logic [c_baud_w-1:0] r_baud;
  logic                w_tick;

  assign w_tick = (r_baud == c_baud_max);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_baud <= '0;
    else if (w_tick) r_baud <= '0;
    else             r_baud <= r_baud + 1'b1;
  end

  // Input synchroniser
  logic [NUM_BTNS-1:0] r_sync1, r_sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  logic [NUM_BTNS-1:0] w_rise, w_fall;

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
    logic [c_db_w-1:0] r_cnt;
    logic              r_level;
    logic              w_differ;
    logic              w_done;

    assign w_differ = r_sync2[gi] ^ r_level;
    assign w_done   = w_differ && (r_cnt == c_db_max);

    // Any cycle of agreement restarts the stability window
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_rise[gi] = w_done & ~r_level;
    assign w_fall[gi] = w_done &  r_level;
  end

  // Arbitration: lowest pending index wins
  logic [NUM_BTNS-1:0] r_pend_on, r_pend_off, r_sent;
  logic [NUM_BTNS-1:0] w_pend;
  logic                w_found;
  logic [c_idx_w-1:0]  w_sel_idx;
  logic                w_sel_on;
  logic                w_load;

  assign w_pend = r_pend_on | r_pend_off;

  always_comb begin
    w_found   = 1'b0;
    w_sel_idx = '0;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_found   = 1'b1;
        w_sel_idx = c_idx_w'(i);
      end
    end
  end

  // With both edges pending, play whichever restores alternation with sent[]
  assign w_sel_on = r_pend_on[w_sel_idx] &
                    (~r_pend_off[w_sel_idx] | ~r_sent[w_sel_idx]);
  assign w_load   = (r_state == S_IDLE) && w_found;

  logic [NUM_BTNS-1:0] w_sel_mask, w_clr_on, w_clr_off;

  assign w_sel_mask = w_load ? (NUM_BTNS'(1) << w_sel_idx) : '0;
  assign w_clr_on   = w_sel_mask & {NUM_BTNS{w_sel_on}};
  assign w_clr_off  = w_sel_mask & {NUM_BTNS{~w_sel_on}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_on  <= '0;
      r_pend_off <= '0;
      r_sent     <= '0;
    end else begin
      r_pend_on  <= (r_pend_on  & ~w_clr_on)  | w_rise;
      r_pend_off <= (r_pend_off & ~w_clr_off) | w_fall;
      r_sent     <= (r_sent & ~w_sel_mask) | w_clr_on;
    end
  end

  // Message assembly
  logic [7:0] r_last_status;
  logic [7:0] w_status;
  logic [7:0] w_note;
  logic [7:0] w_vel;
  logic       w_skip;

  assign w_status = {((w_sel_on || c_rs) ? 4'h9 : 4'h8), channel};
  assign w_note   = {1'b0, c_base + 7'(w_sel_idx)};
  assign w_vel    = w_sel_on ? c_velocity : 8'h00;
  assign w_skip   = c_rs && (w_status == r_last_status);

  // FSM
  logic [2:0] r_bit_cnt;
  logic [1:0] r_bytes_left;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_next = S_LOAD;
      S_LOAD:  if (w_tick)  w_state_next = S_START;
      S_START: if (w_tick)  w_state_next = S_DATA;
      S_DATA:  if (w_tick && (r_bit_cnt == 3'd7)) w_state_next = S_STOP;
      S_STOP:  if (w_tick)  w_state_next = (r_bytes_left != 2'd0) ? S_START : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Serialiser datapath; the line only moves on a tick
  logic [23:0] r_msg;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_busy;
  logic        r_led;
  logic        w_next_byte;

  assign w_next_byte = w_tick &&
                       ((r_state == S_LOAD) ||
                        ((r_state == S_STOP) && (r_bytes_left != 2'd0)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_msg         <= '0;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_bytes_left  <= '0;
      r_last_status <= 8'h00;
      r_tx          <= 1'b1;
      r_busy        <= 1'b0;
      r_led         <= 1'b0;
    end else if (w_load) begin
      r_msg         <= w_skip ? {8'h00, w_vel, w_note} : {w_vel, w_note, w_status};
      r_bytes_left  <= w_skip ? 2'd2 : 2'd3;
      r_last_status <= w_status;
      r_busy        <= 1'b1;
      r_led         <= 1'b1;
    end else if (w_next_byte) begin
      r_tx         <= 1'b0;
      r_shift      <= r_msg[7:0];
      r_msg        <= {8'h00, r_msg[23:8]};
      r_bytes_left <= r_bytes_left - 2'd1;
    end else if (w_tick) begin
      case (r_state)
        S_START: begin
          r_tx      <= r_shift[0];
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_cnt <= 3'd0;
        end
        S_DATA: begin
          if (r_bit_cnt == 3'd7) begin
            r_tx <= 1'b1;
          end else begin
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        S_STOP: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          r_led  <= 1'b0;
        end
        default: r_tx <= 1'b1;
      endcase
    end
  end

  assign midi_tx = r_tx;
  assign busy    = r_busy;
  assign led     = r_led;

endmodule
`default_nettype wire
